// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, LSB-first data, optional parity, 1-2 stop bits.
// Define UART_RX_MAJORITY_EN to decide each bit by majority vote over the last three synchronised samples.
module uart_rx #(
  parameter int ClockDivider = 8,
  parameter int DataBits     = 8,
  parameter int StopBits     = 1,
  parameter int Parity       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [DataBits-1:0] data_out,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic                parity_error,
  output logic                frame_error,
  output logic                overrun,
  output logic                busy
);

  localparam int CW = (ClockDivider > 1) ? $clog2(ClockDivider) : 1;
  localparam logic [CW-1:0] LAST      = CW'(ClockDivider - 1);
  localparam logic [CW-1:0] HALF      = CW'(ClockDivider / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DataBits - 1);
  localparam logic [3:0]    STOP_LAST = 4'(StopBits - 1);
  localparam logic          ODD       = (Parity == 2);

  if (DataBits < 5 || DataBits > 9) begin : g_bad_databits
    $error("uart_rx: DataBits must be in 5..9");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stopbits
    $error("uart_rx: StopBits must be 1 or 2");
  end
  if (Parity < 0 || Parity > 2) begin : g_bad_parity
    $error("uart_rx: Parity must be 0, 1 or 2");
  end
  if (ClockDivider < 4) begin : g_bad_divider
    $error("uart_rx: ClockDivider must be at least 4");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [3:0]          bit_cnt;
  logic [DataBits-1:0] shreg;
  logic                par_err_q;
  logic                frm_err_q;
  logic                deliver;
  logic                rx_m;
  logic                rx_s;
  logic                bit_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '1;
    else     hist <= {hist[0], rx_s};
  end

  assign bit_val = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign bit_val = rx_s;
`endif

  // Frame FSM; deliver is a one-cycle strobe raised on the last stop sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      deliver   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      deliver <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (!bit_val) begin
              state     <= DATA;
              bit_cnt   <= '0;
              par_err_q <= 1'b0;
              frm_err_q <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {bit_val, shreg[DataBits-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (Parity != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == LAST) begin
            cnt       <= '0;
            par_err_q <= ((^shreg) ^ bit_val) != ODD;
            state     <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!bit_val) frm_err_q <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
              busy    <= 1'b0;
              deliver <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A new word replaces the held one only if the held one is free or being accepted now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      parity_error   <= 1'b0;
      frame_error    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;
      if (deliver) begin
        if (!data_out_valid || data_out_ready) begin
          data_out       <= shreg;
          parity_error   <= par_err_q;
          frame_error    <= frm_err_q;
          data_out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx (8 data bits, even parity, 2 stop bits, divider 8).
module tb_uart_rx;

  localparam int CD   = 8;
  localparam int DB   = 8;
  localparam int SB   = 2;
  localparam int PAR  = 1;
  localparam int HALF = CD / 2 - 1;
  // start edge -> 3 cycles to START, HALF+1 to start sample, CD per further bit, +1 to valid
  localparam int LAT  = 3 + HALF + 1 + CD * (DB + ((PAR != 0) ? 1 : 0) + SB) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready = 1'b0;
  logic          parity_error;
  logic          frame_error;
  logic          overrun;
  logic          busy;

  always #5 clk = ~clk;

  uart_rx #(
    .ClockDivider(CD),
    .DataBits(DB),
    .StopBits(SB),
    .Parity(PAR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .parity_error(parity_error),
    .frame_error(frame_error),
    .overrun(overrun),
    .busy(busy)
  );

  typedef struct {
    logic [DB-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   exp_ovr = 0;
  int   seen_ovr = 0;
  int   ready_mode = 0;
  int   n;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endfunction

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       data_out_ready = 1'b0;
      1:       data_out_ready = 1'b1;
      default: data_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) seen_ovr++;
      if (data_out_valid && data_out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h with no word expected at %0t", data_out, $time);
        end else begin
          mon_e = sb_q.pop_front();
          chk("word_data", 32'(data_out), 32'(mon_e.d));
          chk("word_parity_error", 32'(parity_error), 32'(mon_e.pe));
          chk("word_frame_error", 32'(frame_error), 32'(mon_e.fe));
        end
      end
    end
  end

  task automatic cycles(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame and records what the receiver must present for it.
  task automatic send_frame(input logic [DB-1:0] d, input bit flip_par, input bit [1:0] stop_low,
                            input int glitch_bit, input bit drop);
    logic bits[$];
    exp_t e;
    logic par;
    par = (^d) ^ (PAR == 2) ^ flip_par;
    if (drop) begin
      exp_ovr++;
    end else begin
      e.d  = d;
      e.pe = flip_par;
      e.fe = |stop_low;
      sb_q.push_back(e);
    end
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PAR != 0) bits.push_back(par);
    for (int i = 0; i < SB; i++) bits.push_back(~stop_low[i]);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < CD; c++) begin
        rx = (b == glitch_bit && c == CD / 2) ? ~bits[b] : bits[b];
        @(posedge clk);
        #1;
      end
    end
    rx = 1'b1;
    if (|stop_low) cycles(CD);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DB-1:0] v;
    logic [DB-1:0] d;
    bit            flip;
    bit [1:0]      sl;
    int            gap;

    cycles(3);
    chk("reset_valid", 32'(data_out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);
    chk("reset_parity_error", 32'(parity_error), 32'd0);
    chk("reset_frame_error", 32'(frame_error), 32'd0);
    rst = 1'b0;
    cycles(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // first word: exact latency, then held while not accepted
    fork
      send_frame(8'hA5, 1'b0, 2'b00, -1, 1'b0);
      begin
        n = 0;
        while (!data_out_valid && n < LAT + 50) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    chk("a5_latency", 32'(n), 32'(LAT));
    cycles(20);
    chk("a5_hold_valid", 32'(data_out_valid), 32'd1);
    chk("a5_hold_data", 32'(data_out), 32'hA5);
    ready_mode = 1;
    cycles(3);
    chk("a5_valid_drop", 32'(data_out_valid), 32'd0);
    chk("a5_popped", 32'(sb_q.size()), 32'd0);

    // parity error, clean parity, framing error, clean follow-up
    send_frame(8'h03, 1'b1, 2'b00, -1, 1'b0);
    send_frame(8'h03, 1'b0, 2'b00, -1, 1'b0);
    send_frame(8'h55, 1'b0, 2'b01, -1, 1'b0);
    send_frame(8'h12, 1'b0, 2'b00, -1, 1'b0);
    wait_drain();

    // short low pulse in IDLE is rejected
    rx = 1'b0;
    cycles(2);
    rx = 1'b1;
    cycles(2);
    chk("glitch_busy_rise", 32'(busy), 32'd1);
    cycles(28);
    chk("glitch_busy_back", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(data_out_valid), 32'd0);

    // overrun: second word dropped while first is unaccepted
    ready_mode = 0;
    cycles(2);
    send_frame(8'h11, 1'b0, 2'b00, -1, 1'b0);
    send_frame(8'h22, 1'b0, 2'b00, -1, 1'b1);
    cycles(4);
    chk("overrun_pulses", 32'(seen_ovr), 32'(exp_ovr));
    chk("overrun_valid", 32'(data_out_valid), 32'd1);
    chk("overrun_kept_data", 32'(data_out), 32'h11);
    ready_mode = 1;
    cycles(3);
    chk("overrun_valid_drop", 32'(data_out_valid), 32'd0);
    chk("overrun_popped", 32'(sb_q.size()), 32'd0);

    // accept and deliver in the same cycle: no overrun, new word follows
    ready_mode = 0;
    cycles(2);
    send_frame(8'h5A, 1'b0, 2'b00, -1, 1'b0);
    fork
      send_frame(8'hA6, 1'b0, 2'b00, -1, 1'b0);
      begin
        cycles(LAT - 1);
        ready_mode = 1;
        cycles(1);
        ready_mode = 0;
      end
    join
    cycles(3);
    chk("swap_valid", 32'(data_out_valid), 32'd1);
    chk("swap_data", 32'(data_out), 32'hA6);
    chk("swap_no_overrun", 32'(seen_ovr), 32'(exp_ovr));
    ready_mode = 1;
    wait_drain();

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hFF, 1'b0, 2'b00, 1 + 3, 1'b0);
    wait_drain();
`endif

    // reset in the middle of the data bits
    cycles(2);
    v = 8'h3C;
    rx = 1'b0;
    cycles(CD);
    for (int i = 0; i < 3; i++) begin
      rx = v[i];
      cycles(CD);
    end
    chk("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midreset_data", 32'(data_out), 32'd0);
    chk("midreset_valid", 32'(data_out_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_flags", 32'({parity_error, frame_error, overrun}), 32'd0);
    rx = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(30);
    chk("after_reset_valid", 32'(data_out_valid), 32'd0);
    chk("after_reset_busy", 32'(busy), 32'd0);
    send_frame(8'hC3, 1'b0, 2'b00, -1, 1'b0);
    wait_drain();

    // randomized frames, errors and gaps with random ready
    ready_mode = 2;
    for (int f = 0; f < 24; f++) begin
      d    = DB'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      sl   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      gap  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
      send_frame(d, flip, sl, -1, 1'b0);
      cycles(gap);
    end
    wait_drain();
    cycles(5);
    chk("overrun_total", 32'(seen_ovr), 32'(exp_ovr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: recovers asynchronous frames from a single input line and delivers each data word to the core over a valid/ready handshake. Parameter set and frame format match the UART transmitter of this design (start bit, LSB-first data, optional parity, 1–2 stop bits). Sits between the board RX pin and the CPU's UART peripheral register file. Reports parity, framing and overrun errors.

## Interface
- ClockDivider, 8, clk cycles per bit period; ≥ 4.
- DataBits, 8, data bits per frame; 5..9, checked at elaboration.
- StopBits, 1, stop bits checked; 1 or 2.
- Parity, 0, 0 = none, 1 = even, 2 = odd.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  raw serial line, idle high, asynchronous to clk.
- data_out  out  DataBits  received word, stable while data_out_valid.
- data_out_valid  out  1  word available; held until accepted.
- data_out_ready  in  1  consumer accepts word when high with valid.
- parity_error  out  1  parity mismatch on the word presented; qualified by data_out_valid.
- frame_error  out  1  a stop bit sampled low on the word presented; qualified by data_out_valid.
- overrun  out  1  one-cycle pulse: a frame completed while the previous word was unaccepted.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- rx passes a 2-flop synchronizer (reset value 1); all logic uses the synchronized bit rx_s.
- Sample point: HalfCount = ClockDivider/2 − 1 (integer division). Bit counter counts 0..ClockDivider−1, wrapping.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s = 0 → START, counter ← 0.
  - START: at counter = HalfCount, sampled bit 0 → DATA, counter ← 0; sampled 1 → IDLE (glitch rejected, nothing delivered).
  - DATA: sample at counter = ClockDivider−1 (mid-bit), shift in LSB-first; after DataBits samples → PARITY if Parity ≠ 0, else STOP.
  - PARITY: one sample; error if data XOR parity bit ≠ 0 (even) or ≠ 1 (odd).
  - STOP: StopBits samples; any low sets frame error. After last sample → IDLE and deliver.
- Deliver (cycle after last stop sample): if data_out_valid = 0, load data_out, parity_error, frame_error, set valid. If valid = 1 and data_out_ready = 0, drop the new word, pulse overrun, keep old word. If valid = 1 and ready = 1 in the same cycle, accept old and load new word (valid stays high, no overrun).
- Handshake: valid & ready → valid clears next cycle unless a simultaneous delivery occurs.
- Return to IDLE at mid-stop-bit; a start edge immediately following is detected.
- Frames with errors are still delivered with flags set.

## Timing
- Reset: state IDLE, counter 0, data_out 0, data_out_valid 0, parity_error 0, frame_error 0, overrun 0, busy 0, sync flops 1. Reset mid-frame aborts; no partial word is delivered.
- Edge-to-START: 2 cycles of sync + 1 cycle state update.
- data_out_valid rises exactly 1 cycle after the last stop-bit sample cycle.
- Sample spacing within a frame is exactly ClockDivider cycles.
- Throughput: back-to-back frames at full line rate, no gaps required.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value (including start validation) is the majority of the last three rx_s values at the sample cycle; single-cycle glitches on rx are rejected. Sample cycles unchanged.
- Undefined: bit value is the single rx_s value at the sample cycle.

## Test plan
- ClockDivider=8, 8N1, send 0xA5 → data_out=0xA5, valid 1 cycle after stop sample, parity_error=0, frame_error=0, held until ready.
- Parity=1 (even), send 0x03 with parity bit 1 → parity_error=1, data_out=0x03; with parity bit 0 → parity_error=0.
- Send 0x55 with stop bit driven low → frame_error=1, data_out=0x55; next correct frame 0x12 received cleanly.
- Two frames 0x11, 0x22 back-to-back with ready held low → data_out=0x11, overrun pulses once at second delivery; ready=1 then → valid drops.
- rx low for 2 cycles then high in IDLE → no delivery, busy returns to 0; with UART_RX_MAJORITY_EN, 1-cycle low glitch at data mid-bit of 0xFF → data_out=0xFF.
- Assert rst during DATA of 0x3C → all outputs reset, no valid; following frame 0xC3 received correctly.
